// File: rtl/uart_tx_ctrl.sv
// UART window write controller: buffers CPU stores in a small FIFO
// and drains them one byte at a time into the UART TX core.
module uart_tx_ctrl #(
    parameter  int DEPTH    = 4,
    parameter  int OFFSET_W = 5,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [OFFSET_W-1:0] req_offset,
    input  logic [31:0]         req_data,
    output logic                req_stall,
    input  logic                uart_full,
    output logic                uart_wr,
    output logic [7:0]          uart_data,
    output logic [CW-1:0]       fifo_count,
    output logic                fifo_empty,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          uart_wr_q, uart_wr_d;
    logic [7:0]    uart_data_q, uart_data_d;
    logic          err_q, err_d;
    logic          hit_tx, hit_bad;
    logic          full, push, pop;
    logic          unused_hi;

    assign hit_tx    = req_valid && (req_offset == '0);
    assign hit_bad   = req_valid && (req_offset != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign req_stall = hit_tx && full;
    assign push      = hit_tx && !full;
    assign unused_hi = ^req_data[31:8];

    // Drain FSM; an empty FIFO forwards the incoming byte so the
    // strobe follows acceptance by exactly one cycle.
    always_comb begin
        state_d     = state_q;
        uart_wr_d   = 1'b0;
        uart_data_d = uart_data_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((count_q != '0 || push) && !uart_full) begin
                    state_d     = WRITE;
                    uart_wr_d   = 1'b1;
                    uart_data_d = (count_q == '0) ? req_data[7:0]
                                                  : mem_q[rptr_q];
                end
            end
            WRITE: begin
                pop     = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy and sticky error next-state
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q || hit_bad;
    end

    // State, pointers, FIFO storage and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            uart_wr_q   <= 1'b0;
            uart_data_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            uart_wr_q   <= uart_wr_d;
            uart_data_q <= uart_data_d;
            err_q       <= err_d;
            if (push) begin
                mem_q[wptr_q] <= req_data[7:0];
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
        end
    end

    assign uart_wr    = uart_wr_q;
    assign uart_data  = uart_data_q;
    assign fifo_count = count_q;
    assign fifo_empty = (count_q == '0);
    assign err        = err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl (DEPTH = 4).
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [4:0]  req_offset = '0;
    logic [31:0] req_data = '0;
    logic        uart_full = 1'b0;
    logic        req_stall;
    logic        uart_wr;
    logic [7:0]  uart_data;
    logic [2:0]  fifo_count;
    logic        fifo_empty;
    logic        err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    uart_tx_ctrl #(.DEPTH(4), .OFFSET_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_offset (req_offset),
        .req_data   (req_data),
        .req_stall  (req_stall),
        .uart_full  (uart_full),
        .uart_wr    (uart_wr),
        .uart_data  (uart_data),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [4:0] off, input logic [7:0] b);
        req_valid  = 1'b1;
        req_offset = off;
        req_data   = {24'hABCDEF, b};
    endtask

    // Wait (bounded) for the next strobe; check byte and spacing
    task automatic expect_byte(input string tag, input logic [7:0] b,
                               input int gap);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (uart_wr === 1'b1) begin
                n    = i;
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_data"}, 32'(uart_data), 32'(b));
        chk({tag, "_gap"}, n, gap);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        // Reset state while rst_n is held low
        #12;
        chk("rst_wr", 32'(uart_wr), 32'd0);
        chk("rst_data", 32'(uart_data), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(req_stall), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_wr", 32'(uart_wr), 32'd0);

        // Single byte: strobe one cycle after acceptance
        store(5'd0, 8'h41);
        #1;
        chk("single_stall", 32'(req_stall), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("single_wr", 32'(uart_wr), 32'd1);
        chk("single_data", 32'(uart_data), 32'h41);
        chk("single_cnt", 32'(fifo_count), 32'd1);
        tick();
        chk("single_hold", 32'(uart_wr), 32'd0);
        chk("single_empty", 32'(fifo_empty), 32'd1);
        tick();
        chk("single_keep", 32'(uart_data), 32'h41);

        // Illegal offset: dropped, no stall, sticky error
        store(5'd4, 8'h55);
        #1;
        chk("bad_stall", 32'(req_stall), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_count", 32'(fifo_count), 32'd0);
        chk("bad_wr", 32'(uart_wr), 32'd0);
        tick();
        tick();
        chk("bad_sticky", 32'(err), 32'd1);

        // Fill under back-pressure
        uart_full = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            store(5'd0, 8'(k));
            #1;
            chk("fill_stall", 32'(req_stall), 32'd0);
            tick();
        end
        chk("fill_count", 32'(fifo_count), 32'd4);
        chk("fill_wr", 32'(uart_wr), 32'd0);
        store(5'd4, 8'h55);
        #1;
        chk("full_bad_stall", 32'(req_stall), 32'd0);
        tick();
        store(5'd0, 8'h05);
        uart_full = 1'b0;
        #1;
        chk("full_stall", 32'(req_stall), 32'd1);
        chk("full_count", 32'(fifo_count), 32'd4);
        tick();
        chk("drain1_wr", 32'(uart_wr), 32'd1);
        chk("drain1_data", 32'(uart_data), 32'h01);
        chk("nobypass_stall", 32'(req_stall), 32'd1);
        tick();
        chk("pop_count", 32'(fifo_count), 32'd3);
        chk("pop_stall", 32'(req_stall), 32'd0);
        chk("pop_wr", 32'(uart_wr), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("acc5_count", 32'(fifo_count), 32'd4);
        expect_byte("d02", 8'h02, 1);
        expect_byte("d03", 8'h03, 3);
        expect_byte("d04", 8'h04, 3);
        expect_byte("d05", 8'h05, 3);
        tick();
        chk("drain_empty", 32'(fifo_empty), 32'd1);

        // Push and pop in the same cycle, then wrap the pointers
        uart_full = 1'b1;
        tick();
        store(5'd0, 8'hAA);
        tick();
        store(5'd0, 8'hBB);
        tick();
        req_valid = 1'b0;
        uart_full = 1'b0;
        chk("pp_count2", 32'(fifo_count), 32'd2);
        tick();
        chk("pp_wr", 32'(uart_wr), 32'd1);
        chk("pp_data", 32'(uart_data), 32'hAA);
        store(5'd0, 8'hCC);
        #1;
        chk("pp_stall", 32'(req_stall), 32'd0);
        tick();
        chk("pp_count", 32'(fifo_count), 32'd2);
        store(5'd0, 8'hD0);
        uart_full = 1'b1;
        tick();
        store(5'd0, 8'hD1);
        tick();
        req_valid = 1'b0;
        chk("pp_fill", 32'(fifo_count), 32'd4);
        uart_full = 1'b0;
        expect_byte("dBB", 8'hBB, 1);
        expect_byte("dCC", 8'hCC, 3);
        expect_byte("dD0", 8'hD0, 3);
        expect_byte("dD1", 8'hD1, 3);
        tick();
        uart_full = 1'b1;
        tick();
        for (int k = 2; k <= 5; k++) begin
            store(5'd0, 8'hD0 + 8'(k));
            tick();
        end
        req_valid = 1'b0;
        chk("wrap_fill", 32'(fifo_count), 32'd4);
        uart_full = 1'b0;
        expect_byte("dD2", 8'hD2, 1);
        expect_byte("dD3", 8'hD3, 3);
        expect_byte("dD4", 8'hD4, 3);
        expect_byte("dD5", 8'hD5, 3);
        tick();
        chk("wrap_empty", 32'(fifo_empty), 32'd1);

        // Reset asserted during WRITE with three bytes queued
        uart_full = 1'b1;
        tick();
        store(5'd0, 8'h11);
        tick();
        store(5'd0, 8'h22);
        tick();
        store(5'd0, 8'h33);
        tick();
        req_valid = 1'b0;
        uart_full = 1'b0;
        tick();
        chk("mid_wr", 32'(uart_wr), 32'd1);
        chk("mid_count", 32'(fifo_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(uart_wr), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
        chk("mid_rst_data", 32'(uart_data), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uart_wr === 1'b1) pulses++;
        end
        chk("post_rst_pulses", pulses, 0);
        chk("post_rst_count", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
